mc_main_ctl: RTL and testbench



---
 rtl/mc_pkg.sv | 45 ++++
 rtl/mc_main_ctl.sv | 163 ++++++++++++++++
 tb/tb_mc_main_ctl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS main control FSM:
// state encoding, decoded opcodes and the datapath mux encodings.
package mc_pkg;

    // Control states of the multi-cycle instruction sequence
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEM_ADDR = 4'd2,
        MEM_RD   = 4'd3,
        MEM_WB   = 4'd4,
        MEM_WR   = 4'd5,
        EXECUTE  = 4'd6,
        R_WB     = 4'd7,
        ADDI_EX  = 4'd8,
        ADDI_WB  = 4'd9,
        BRANCH   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    // Supported IR[31:26] opcodes
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    // ALUOp handed to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B-input mux selects
    localparam logic [1:0] ALUB_RT      = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    // PC source mux selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_main_ctl.sv
// Main control FSM for the multi-cycle MIPS datapath. Steps each instruction
// through fetch/decode/execute/memory/writeback, stalling memory states on
// mem_ready. Outputs are decoded from the state, with mem_ready qualifying
// the commit strobes of the memory states.
module mc_main_ctl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t state;
    state_t next_state;

    // Remembers lw vs sw from DECODE so MEM_ADDR never looks at the IR again
    logic is_load;

    // State register plus the load/store flag captured during decode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            is_load <= 1'b0;
        end else begin
            state <= next_state;
            if (state == DECODE) begin
                is_load <= (opcode == OP_LW);
            end
        end
    end

    // Next-state selection; any unknown encoding falls back to FETCH
    always_comb begin
        next_state = FETCH;
        case (state)
            FETCH:    next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: next_state = MEM_ADDR;
                    OP_RTYPE:     next_state = EXECUTE;
                    OP_BEQ:       next_state = BRANCH;
                    OP_J:         next_state = JUMP;
                    OP_ADDI:      next_state = ADDI_EX;
                    default:      next_state = FETCH;
                endcase
            end
            MEM_ADDR: next_state = is_load ? MEM_RD : MEM_WR;
            MEM_RD:   next_state = mem_ready ? MEM_WB : MEM_RD;
            MEM_WB:   next_state = FETCH;
            MEM_WR:   next_state = mem_ready ? FETCH : MEM_WR;
            EXECUTE:  next_state = R_WB;
            R_WB:     next_state = FETCH;
            ADDI_EX:  next_state = ADDI_WB;
            ADDI_WB:  next_state = FETCH;
            BRANCH:   next_state = FETCH;
            JUMP:     next_state = FETCH;
            default:  next_state = FETCH;
        endcase
    end

    // Output decode; everything is forced low while reset is held
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_RT;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;
        if (rst_n) begin
            case (state)
                FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = ALUB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                DECODE: begin
                    alu_src_b = ALUB_IMM_SH2;
                    case (opcode)
                        OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_J, OP_ADDI: illegal_op = 1'b0;
                        default: illegal_op = 1'b1;
                    endcase
                end
                MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    instr_done = mem_ready;
                end
                EXECUTE: begin
                    alu_src_a = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                R_WB: begin
                    reg_write  = 1'b1;
                    reg_dst    = 1'b1;
                    instr_done = 1'b1;
                end
                ADDI_EX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = ALUB_IMM;
                end
                ADDI_WB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = ALUOP_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = PCSRC_ALUOUT;
                    instr_done    = 1'b1;
                end
                JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = PCSRC_JUMP;
                    instr_done = 1'b1;
                end
                default: begin
                    pc_write = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mc_main_ctl.sv
// Self-checking bench for mc_main_ctl: each instruction is expanded into its
// expected per-cycle control word from its instruction class and wait counts.
module tb_mc_main_ctl;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, alu_op, pc_source;

    int compared;
    int mismatched;

    logic [17:0] outs;
    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                   pc_source, illegal_op, instr_done};

    // Single-bit masks of the packed control word
    localparam logic [17:0] M_PCW  = 18'd1 << 17;
    localparam logic [17:0] M_PCWC = 18'd1 << 16;
    localparam logic [17:0] M_IORD = 18'd1 << 15;
    localparam logic [17:0] M_MRD  = 18'd1 << 14;
    localparam logic [17:0] M_MWR  = 18'd1 << 13;
    localparam logic [17:0] M_IRW  = 18'd1 << 12;
    localparam logic [17:0] M_M2R  = 18'd1 << 11;
    localparam logic [17:0] M_RDST = 18'd1 << 10;
    localparam logic [17:0] M_RW   = 18'd1 << 9;
    localparam logic [17:0] M_ASA  = 18'd1 << 8;
    localparam logic [17:0] M_ILL  = 18'd1 << 1;
    localparam logic [17:0] M_DONE = 18'd1;

    // Expected control words for each step of an instruction
    localparam logic [17:0] E_FETCH_WAIT = M_MRD | (18'(2'b01) << 6);
    localparam logic [17:0] E_FETCH_GO   = E_FETCH_WAIT | M_IRW | M_PCW;
    localparam logic [17:0] E_DECODE     = 18'(2'b11) << 6;
    localparam logic [17:0] E_DECODE_ILL = E_DECODE | M_ILL;
    localparam logic [17:0] E_ADDR       = M_ASA | (18'(2'b10) << 6);
    localparam logic [17:0] E_RD         = M_MRD | M_IORD;
    localparam logic [17:0] E_LOAD_WB    = M_RW | M_M2R | M_DONE;
    localparam logic [17:0] E_WR_WAIT    = M_MWR | M_IORD;
    localparam logic [17:0] E_WR_GO      = E_WR_WAIT | M_DONE;
    localparam logic [17:0] E_EXEC       = M_ASA | (18'(2'b10) << 4);
    localparam logic [17:0] E_R_WB       = M_RW | M_RDST | M_DONE;
    localparam logic [17:0] E_ADDI_EX    = M_ASA | (18'(2'b10) << 6);
    localparam logic [17:0] E_ADDI_WB    = M_RW | M_DONE;
    localparam logic [17:0] E_BEQ        = M_ASA | (18'(2'b01) << 4) | M_PCWC | (18'(2'b01) << 2) | M_DONE;
    localparam logic [17:0] E_JUMP       = M_PCW | (18'(2'b10) << 2) | M_DONE;

    mc_main_ctl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_op        (alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .instr_done    (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [17:0] got, input logic [17:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Drives one cycle's inputs just after a falling edge and checks before the rising edge
    task automatic stepCycle(input logic rdy, input logic [5:0] op, input logic [17:0] exp, input string tag);
        mem_ready = rdy;
        opcode    = op;
        #1;
        checkOutput(tag, outs, exp);
        @(negedge clk);
    endtask

    function automatic logic [5:0] noise();
        return 6'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    // Runs one complete instruction: fetch_waits/mem_waits are stall cycles
    task automatic applyStimulus(input logic [5:0] op, input int fetch_waits, input int mem_waits);
        logic legal;
        legal = (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
                (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
        for (int i = 0; i < fetch_waits; i++) stepCycle(1'b0, noise(), E_FETCH_WAIT, "fetch_wait");
        stepCycle(1'b1, noise(), E_FETCH_GO, "fetch");
        stepCycle(rnd_bit(), op, legal ? E_DECODE : E_DECODE_ILL, "decode");
        case (op)
            6'b100011: begin
                stepCycle(rnd_bit(), noise(), E_ADDR, "lw_addr");
                for (int i = 0; i < mem_waits; i++) stepCycle(1'b0, noise(), E_RD, "lw_rd_wait");
                stepCycle(1'b1, noise(), E_RD, "lw_rd");
                stepCycle(rnd_bit(), noise(), E_LOAD_WB, "lw_wb");
            end
            6'b101011: begin
                stepCycle(rnd_bit(), noise(), E_ADDR, "sw_addr");
                for (int i = 0; i < mem_waits; i++) stepCycle(1'b0, noise(), E_WR_WAIT, "sw_wait");
                stepCycle(1'b1, noise(), E_WR_GO, "sw_done");
            end
            6'b000000: begin
                stepCycle(rnd_bit(), noise(), E_EXEC, "r_exec");
                stepCycle(rnd_bit(), noise(), E_R_WB, "r_wb");
            end
            6'b001000: begin
                stepCycle(rnd_bit(), noise(), E_ADDI_EX, "addi_ex");
                stepCycle(rnd_bit(), noise(), E_ADDI_WB, "addi_wb");
            end
            6'b000100: stepCycle(rnd_bit(), noise(), E_BEQ, "beq");
            6'b000010: stepCycle(rnd_bit(), noise(), E_JUMP, "jump");
            default: ;
        endcase
    endtask

    initial begin
        logic [5:0] legal_ops [6];
        logic [5:0] op;
        int         pick;

        compared   = 0;
        mismatched = 0;
        legal_ops  = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001000};
        rst_n      = 1'b0;
        mem_ready  = 1'b0;
        opcode     = 6'b100011;

        // Reset held for three cycles with a lw opcode present
        @(negedge clk);
        for (int i = 0; i < 3; i++) stepCycle(rnd_bit(), 6'b100011, 18'd0, "reset");
        rst_n = 1'b1;

        // Directed instructions
        applyStimulus(6'b100011, 0, 0);
        applyStimulus(6'b000000, 0, 0);
        applyStimulus(6'b000100, 0, 0);
        applyStimulus(6'b101011, 0, 2);
        applyStimulus(6'b111111, 0, 0);
        applyStimulus(6'b001000, 4, 0);
        applyStimulus(6'b000010, 0, 0);

        // lw abandoned by reset while stalled in the memory read
        stepCycle(1'b1, noise(), E_FETCH_GO, "abort_fetch");
        stepCycle(rnd_bit(), 6'b100011, E_DECODE, "abort_decode");
        stepCycle(rnd_bit(), noise(), E_ADDR, "abort_addr");
        stepCycle(1'b0, noise(), E_RD, "abort_rd_wait");
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mid_now", outs, 18'd0);
        @(negedge clk);
        stepCycle(1'b1, noise(), 18'd0, "reset_mid_held");
        rst_n = 1'b1;
        stepCycle(1'b0, noise(), E_FETCH_WAIT, "after_abort");
        applyStimulus(6'b000000, 1, 0);

        // Randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            pick = $urandom_range(0, 7);
            op   = (pick < 6) ? legal_ops[pick] : noise();
            applyStimulus(op,
                          ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                          ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
